wb_write_buffer: RTL
====================

// Module: wb_write_buffer
// PURPOSE
//  Posted-write Wishbone stage between the FSMC bridge (master) and the SDRAM controller (slave).
//  Accepts and acks upstream writes into a small FIFO so the FSMC is not held for SDRAM latency.
//  Drains them to the SDRAM in order. Reads wait until the FIFO is drained, so ordering is strict.
// PARAMETERS
//  AW          24  address width, both sides (top level zero-extends to the SDRAM port)
//  DW          32  data width, both sides
//  SW          4   byte-select width, DW/8
//  DEPTH_LOG2  2   FIFO depth = 2**DEPTH_LOG2 entries, each {adr, dat, sel}
// PORTS
//  clk          in   1      system clock; the only clock
//  rst          in   1      reset, synchronous, active-high
//  wbs_cyc_i    in   1      upstream cycle
//  wbs_stb_i    in   1      upstream strobe
//  wbs_we_i     in   1      upstream write enable
//  wbs_adr_i    in   AW     upstream address
//  wbs_dat_i    in   DW     upstream write data
//  wbs_sel_i    in   SW     upstream byte selects
//  wbs_dat_o    out  DW     upstream read data, valid while wbs_ack_o is high
//  wbs_ack_o    out  1      upstream ack, registered, single-cycle pulse
//  wbm_cyc_o    out  1      downstream cycle
//  wbm_stb_o    out  1      downstream strobe
//  wbm_we_o     out  1      downstream write enable
//  wbm_adr_o    out  AW     downstream address
//  wbm_dat_o    out  DW     downstream write data
//  wbm_sel_o    out  SW     downstream byte selects
//  wbm_dat_i    in   DW     downstream read data
//  wbm_ack_i    in   1      downstream ack
//  wbuf_level   out  DEPTH_LOG2+1  FIFO occupancy
//  wbuf_full    out  1      occupancy == 2**DEPTH_LOG2
//  wbuf_empty   out  1      occupancy == 0
// BEHAVIOUR
//  Reset: all outputs 0 except wbuf_empty=1; pointers 0; FSM to IDLE.
//   Any in-flight downstream access is abandoned: wbm_cyc_o drops on the reset edge.
//  Push: when cyc&stb&we & !wbuf_full & !wbs_ack_o, write {adr,dat,sel} into the FIFO.
//   wbs_ack_o goes high the next cycle for exactly one cycle. Write latency is 1 cycle.
//  Full: no ack and no push while full.
//   A pop in cycle N clears full at N+1; the push is taken at N+1 and acked at N+2.
//  Push and pop in the same cycle: both occur and the level is unchanged.
//  Full is the registered flag, so a push never relies on a same-cycle pop.
//  Pointers are DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1).
//   full = (MSBs differ and lower bits equal); level = wr_ptr - rd_ptr, truncated.
//  Downstream FSM:
//   IDLE: if !empty, go to WRITE. Else if an upstream read is pending, go to READ.
//         Writes have priority over reads.
//   WRITE: drive the FIFO head with cyc=stb=we=1 and hold it stable.
//          On wbm_ack_i, pop, deassert cyc/stb on the same edge, and go to IDLE.
//   READ: drive cyc=stb=1, we=0, adr=wbs_adr_i, sel=wbs_sel_i.
//         On wbm_ack_i, register wbm_dat_i into wbs_dat_o and go to RACK.
//   RACK: wbs_ack_o=1 for one cycle, then go to IDLE.
//  There is at least one IDLE cycle between downstream transactions.
//  Read latency = drain time + 2 + downstream latency.
//  Upstream abort: if wbs_cyc_i drops before READ is entered, nothing is issued.
//   If it drops in READ, the downstream access completes, the data is discarded, and no ack is given.
//  wbs_dat_o keeps the last read value; it is meaningful only while wbs_ack_o is high.
// CONFIGURATION
//  WB_WBUF_STATS_EN defined: adds output wbuf_posted_cnt [15:0] and output wbuf_max_level [DEPTH_LOG2:0].
//   wbuf_posted_cnt increments on each push and wraps at 16'hFFFF->0.
//   wbuf_max_level is a high-water mark.
//   Both are cleared by rst and reset to 0.
//  WB_WBUF_STATS_EN undefined: these ports and this logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package wb_wbuf_pkg holds:
//   - FSM state encoding: IDLE, WRITE, READ, RACK
//   - entry width constant ENTRY_W = AW+DW+SW
//   - field offset constants for unpacking FIFO entries
//  Sub-module wb_wbuf_fifo: synchronous register-array FIFO with push/pop/level/full/empty, no read latency.
//   wb_write_buffer instantiates it and owns the handshake logic and the FSM.
// TESTING
//  1. Single write adr=24'h000010, dat=32'hDEADBEEF, sel=4'hF:
//     wbs_ack_o at +1; downstream write with identical fields; level returns to 0.
//  2. Downstream ack held off; 5 back-to-back writes (DEPTH=4):
//     4 acks, wbuf_full=1, 5th stalls; release ack -> 5th acked 2 cycles after first pop; order preserved.
//  3. 3 posted writes, then a read of the same adr:
//     no downstream read until empty; returned dat equals the last write.
//  4. Read in flight, wbs_cyc_i dropped:
//     downstream completes, no wbs_ack_o, FSM back in IDLE.
//  5. rst asserted in WRITE with level=3:
//     next cycle wbm_cyc_o=0, level=0, wbuf_empty=1.
//  6. WB_WBUF_STATS_EN, 70000 writes:
//     wbuf_posted_cnt=16'd4464 (70000 mod 65536); wbuf_max_level reflects the peak level.

Source files
------------

// File: rtl/wb_wbuf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_wbuf_pkg
//  Purpose  : Shared state encoding, entry width and entry field offsets for
//             the posted-write Wishbone buffer.
//  Revision : 1.0  initial release
// ============================================================================
package wb_wbuf_pkg;

  localparam int AW_DEF         = 24;
  localparam int DW_DEF         = 32;
  localparam int SW_DEF         = 4;
  localparam int DEPTH_LOG2_DEF = 2;

  // Entry layout, LSB first: {adr, dat, sel}
  localparam int ENTRY_W = AW_DEF + DW_DEF + SW_DEF;
  localparam int SEL_LSB = 0;
  localparam int DAT_LSB = SW_DEF;
  localparam int ADR_LSB = SW_DEF + DW_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RACK  = 2'd3
  } wbuf_state_t;

  function automatic int entry_w(input int aw, input int dw, input int sw);
    return aw + dw + sw;
  endfunction

  function automatic int dat_lsb(input int sw);
    return SEL_LSB + sw;
  endfunction

  function automatic int adr_lsb(input int dw, input int sw);
    return SEL_LSB + sw + dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_wbuf_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : wb_wbuf_fifo
//  Purpose  : Register-array FIFO, zero read latency, wrap-bit pointers.
//  Revision : 1.0  initial release
// ============================================================================
module wb_wbuf_fifo
  import wb_wbuf_pkg::*;
#(
  parameter int WIDTH      = ENTRY_W,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      pop_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int c_depth = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0]    r_mem [c_depth];
  logic [DEPTH_LOG2:0] r_wr_ptr;
  logic [DEPTH_LOG2:0] r_rd_ptr;
  logic                w_do_push;
  logic                w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
  end

  assign pop_data = r_mem[r_rd_ptr[DEPTH_LOG2-1:0]];
  assign empty    = (r_wr_ptr == r_rd_ptr);
  assign full     = (r_wr_ptr[DEPTH_LOG2] != r_rd_ptr[DEPTH_LOG2]) &&
                    (r_wr_ptr[DEPTH_LOG2-1:0] == r_rd_ptr[DEPTH_LOG2-1:0]);
  assign level    = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/wb_write_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : wb_write_buffer
//  Purpose  : Posted-write Wishbone stage; writes are acked into a FIFO and
//             drained in order, reads wait for the drain. Optional statistics
//             ports are enabled with WB_WBUF_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module wb_write_buffer
  import wb_wbuf_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter int SW         = SW_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [AW-1:0]         wbs_adr_i,
  input  logic [DW-1:0]         wbs_dat_i,
  input  logic [SW-1:0]         wbs_sel_i,
  output logic [DW-1:0]         wbs_dat_o,
  output logic                  wbs_ack_o,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [AW-1:0]         wbm_adr_o,
  output logic [DW-1:0]         wbm_dat_o,
  output logic [SW-1:0]         wbm_sel_o,
  input  logic [DW-1:0]         wbm_dat_i,
  input  logic                  wbm_ack_i,
  output logic [DEPTH_LOG2:0]   wbuf_level,
  output logic                  wbuf_full,
  output logic                  wbuf_empty
`ifdef WB_WBUF_STATS_EN
  ,
  output logic [15:0]           wbuf_posted_cnt,
  output logic [DEPTH_LOG2:0]   wbuf_max_level
`endif
);

  localparam int c_entry_w = entry_w(AW, DW, SW);
  localparam int c_dat_lsb = dat_lsb(SW);
  localparam int c_adr_lsb = adr_lsb(DW, SW);

  wbuf_state_t          r_state;
  wbuf_state_t          w_state_next;
  logic                 r_ack;
  logic [DW-1:0]        r_dat;
  logic                 r_rd_abort;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rd_req;
  logic                 w_rd_capture;
  logic [c_entry_w-1:0] w_head;

  assign w_push   = wbs_cyc_i & wbs_stb_i & wbs_we_i & ~wbuf_full & ~r_ack;
  assign w_rd_req = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;
  assign w_pop    = (r_state == ST_WRITE) & wbm_ack_i;

  wb_wbuf_fifo #(
    .WIDTH      (c_entry_w),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data ({wbs_adr_i, wbs_dat_i, wbs_sel_i}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .level     (wbuf_level),
    .full      (wbuf_full),
    .empty     (wbuf_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_dat      <= '0;
      r_rd_abort <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ack      <= w_push | w_rd_capture;
      if (w_rd_capture) r_dat <= wbm_dat_i;
      // Remembers an upstream drop anywhere inside READ, even if cyc returns.
      r_rd_abort <= (r_state == ST_READ) & (r_rd_abort | ~wbs_cyc_i);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rd_capture = 1'b0;
    wbm_cyc_o    = 1'b0;
    wbm_stb_o    = 1'b0;
    wbm_we_o     = 1'b0;
    wbm_adr_o    = '0;
    wbm_dat_o    = '0;
    wbm_sel_o    = '0;
    case (r_state)
      ST_IDLE: begin
        if (!wbuf_empty)   w_state_next = ST_WRITE;
        else if (w_rd_req) w_state_next = ST_READ;
      end
      ST_WRITE: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = 1'b1;
        wbm_adr_o = w_head[c_adr_lsb +: AW];
        wbm_dat_o = w_head[c_dat_lsb +: DW];
        wbm_sel_o = w_head[SEL_LSB +: SW];
        if (wbm_ack_i) w_state_next = ST_IDLE;
      end
      ST_READ: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_adr_o = wbs_adr_i;
        wbm_sel_o = wbs_sel_i;
        if (wbm_ack_i) begin
          if (r_rd_abort || !wbs_cyc_i) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_RACK;
            w_rd_capture = 1'b1;
          end
        end
      end
      ST_RACK: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef WB_WBUF_STATS_EN
  logic [15:0]         r_posted_cnt;
  logic [DEPTH_LOG2:0] r_max_level;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_posted_cnt <= '0;
      r_max_level  <= '0;
    end else begin
      if (w_push) r_posted_cnt <= r_posted_cnt + 16'd1;
      if (wbuf_level > r_max_level) r_max_level <= wbuf_level;
    end
  end

  assign wbuf_posted_cnt = r_posted_cnt;
  assign wbuf_max_level  = r_max_level;
`endif

endmodule
`default_nettype wire
